fib_seq_gen: RTL

FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

---
 rtl/fib_seq_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: iterative Fibonacci term generator feeding a 4-digit display.
// A start request loads the index, iterates a<=b, b<=a+b once per cycle and
// presents F(n) on fib_out with valid. Terms above DEC_MAX raise ovf.
// Optional macro FIB_OVF_SAT_EN: on overflow show DEC_MAX (valid=1) instead
// of blanking the display (valid=0).
module fib_seq_gen #(
  parameter int W       = 14,
  parameter int DEC_MAX = 9999
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [4:0]   n_in,
  output logic [W-1:0] fib_out,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [W:0]   LIM     = (W+1)'(DEC_MAX);
  localparam logic [W-1:0] SAT_VAL = W'(DEC_MAX);

  state_t     state, state_nx;
  logic [W:0] a, b;       // W+1 bits so a+b never wraps
  logic [4:0] k;          // iterations still to run
  logic       ovf_hit;

  // next a would be b; stop as soon as it cannot be displayed
  assign ovf_hit = (state == CALC) && (b > LIM) && (k != 5'd0);

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: the final iteration and the move to DONE share one cycle,
  // so n iterations take exactly n CALC cycles (n=0 skips CALC entirely)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: state_nx = (n_in == 5'd0) ? DONE : CALC;
      CALC: if (ovf_hit || k <= 5'd1) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // status outputs decoded straight from the state register
  always_comb begin
    busy = (state == LOAD) || (state == CALC);
    done = (state == DONE);
  end

  // datapath and result registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a       <= '0;
      b       <= '0;
      k       <= '0;
      fib_out <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          a       <= '0;
          b       <= (W+1)'(1);
          k       <= n_in;
          fib_out <= '0;
          valid   <= 1'b0;
          ovf     <= 1'b0;
        end
        CALC: begin
          if (ovf_hit) begin
            ovf <= 1'b1;
          end else if (k != 5'd0) begin
            a <= b;
            b <= a + b;
            k <= k - 5'd1;
          end
        end
        DONE: begin
          if (!ovf) begin
            fib_out <= a[W-1:0];
            valid   <= 1'b1;
          end else begin
`ifdef FIB_OVF_SAT_EN
            fib_out <= SAT_VAL;
            valid   <= 1'b1;
`else
            fib_out <= '0;
            valid   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
